bin2bcd_seq: RTL

//  Sequential binary-to-BCD converter (shift-and-add-3 "double dabble"), one bit per cycle.

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_add3_cell.sv | 16 +
 rtl/bin2bcd_seq.sv | 137 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg -- types and constants shared by the binary-to-BCD converter
// and the downstream BCD-to-7-segment decoder.
//   BCD_BLANK   : nibble value the decoder renders as a dark digit
//   b2b_state_t : converter FSM state encoding
//   bcd_digit_t : one packed BCD digit
package bcd_pkg;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } b2b_state_t;

  typedef logic [3:0] bcd_digit_t;

endpackage : bcd_pkg

// File: rtl/bcd_add3_cell.sv
// bcd_add3_cell -- double-dabble correction for one BCD digit.
// A digit of 5 or more is bumped by 3 so that the following left shift
// carries into the next decimal digit instead of producing 10..15.
// Ports:
//   digit_in  : BCD digit before correction
//   digit_out : corrected digit (4-bit wrap never happens for inputs 0..9)
module bcd_add3_cell
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_in,
  output bcd_digit_t digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? bcd_digit_t'(digit_in + 4'd3) : digit_in;

endmodule : bcd_add3_cell

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential binary-to-BCD converter (shift-and-add-3),
// one input bit per clock, valid/ready on both sides.
// After the accept edge the FSM spends WIDTH cycles in SHIFT, loads bcd_out
// on the last of them and then holds the result in DONE until out_ready.
// Configuration macro: BIN2BCD_BLANK_EN -- when defined, leading zero
// digits above digit 0 are replaced by BCD_BLANK on the load into bcd_out.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   ena       : global enable; low freezes every register
//   bin_in    : unsigned binary value, sampled on the accept edge only
//   in_valid  : bin_in valid
//   in_ready  : converter idle and enabled
//   bcd_out   : packed BCD result, digit 0 in [3:0]
//   out_valid : bcd_out valid (DONE state)
//   out_ready : consumer accepts bcd_out
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [WIDTH-1:0]      bin_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  // The largest binary input must fit in DIGITS decimal digits.
  if ((64'd10 ** DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_param_check
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  logic [1:0]          state;
  logic [WIDTH-1:0]    shreg;
  logic [BW-1:0]       accum;
  logic [CW-1:0]       cnt;

  logic [BW-1:0]       adj;
  logic [BW+WIDTH-1:0] joined;
  logic [BW+WIDTH-1:0] shifted;
  logic [BW-1:0]       accum_nxt;
  logic [WIDTH-1:0]    shreg_nxt;
  logic [BW-1:0]       load_val;

  for (genvar d = 0; d < DIGITS; d++) begin : g_add3
    bcd_add3_cell u_cell (
      .digit_in  (accum[4*d +: 4]),
      .digit_out (adj[4*d +: 4])
    );
  end

  // Corrected accumulator and shift register move left as one long word.
  assign joined    = {adj, shreg};
  assign shifted   = joined << 1;
  assign accum_nxt = shifted[BW+WIDTH-1:WIDTH];
  assign shreg_nxt = shifted[WIDTH-1:0];

  assign in_ready = (state == ST_IDLE) & ena;

  // Value presented to bcd_out on the final shift, optionally blanked.
  always_comb begin
    load_val = accum_nxt;
`ifdef BIN2BCD_BLANK_EN
    begin : blank_scan
      logic lead;
      lead = 1'b1;
      // Walk down from the top digit while everything seen so far is zero;
      // digit 0 is never visited so a zero value still shows one 0.
      for (int d = DIGITS - 1; d >= 1; d--) begin
        if (lead && (accum_nxt[4*d +: 4] == 4'd0)) begin
          load_val[4*d +: 4] = BCD_BLANK;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
  end

  // FSM, bit counter, shift register, accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      accum     <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      out_valid <= 1'b0;
    end else if (ena) begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            shreg <= bin_in;
            accum <= '0;
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          accum <= accum_nxt;
          shreg <= shreg_nxt;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            bcd_out   <= load_val;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : bin2bcd_seq
